// File: rtl/shift_add_seq.sv
// Sequential shift-and-add multiplier driving an external 0..3-bit left shifter.
// Each RUN cycle either adds W into the accumulator, shifts W through the shifter, or finishes.
module shift_add_seq #(
   parameter int IN_DATA_WIDTH  = 8,
   parameter int COEF_WIDTH     = 8,
   parameter int OUT_DATA_WIDTH = 21
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [IN_DATA_WIDTH-1:0]  in_data,
   input  logic [COEF_WIDTH-1:0]     coef,
   input  logic [OUT_DATA_WIDTH-1:0] sh_result,
   output logic                      select_line_vld,
   output logic [1:0]                i_shifter_count,
   output logic [OUT_DATA_WIDTH-1:0] sh_data,
   output logic                      busy,
   output logic                      out_vld,
   output logic [OUT_DATA_WIDTH-1:0] out_data
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]                r_state;
   logic [OUT_DATA_WIDTH-1:0] r_work;
   logic [OUT_DATA_WIDTH-1:0] r_acc;
   logic [OUT_DATA_WIDTH-1:0] r_out_data;
   logic [COEF_WIDTH-1:0]     r_rem;
   logic                      r_busy;
   logic                      r_out_vld;
   logic                      w_shift;
   logic [1:0]                w_k;

   // Shift amount: trailing zeros of R clamped to 3 (only used when R[0] is already 0)
   always_comb begin
      w_k = 2'd3;
      if (r_rem[1]) begin
         w_k = 2'd1;
      end else if (r_rem[2]) begin
         w_k = 2'd2;
      end else begin
         w_k = 2'd3;
      end
   end

   // Shifter request decode: a shift step is RUN with a nonzero R whose LSB is clear
   always_comb begin
      w_shift         = (r_state == ST_RUN) && (r_rem != '0) && !r_rem[0];
      select_line_vld = w_shift;
      i_shifter_count = w_shift ? w_k : 2'd0;
      sh_data         = r_work;
   end

   assign busy     = r_busy;
   assign out_vld  = r_out_vld;
   assign out_data = r_out_data;

   // Controller state, datapath registers and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_work     <= '0;
         r_rem      <= '0;
         r_acc      <= '0;
         r_out_data <= '0;
         r_busy     <= 1'b0;
         r_out_vld  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_out_vld <= 1'b0;
               if (start) begin
                  r_work  <= OUT_DATA_WIDTH'(in_data);
                  r_rem   <= coef;
                  r_acc   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (r_rem == '0) begin
                  r_out_data <= r_acc;
                  r_out_vld  <= 1'b1;
                  r_state    <= ST_DONE;
               end else if (r_rem[0]) begin
                  r_acc    <= r_acc + r_work;
                  r_rem[0] <= 1'b0;
               end else begin
                  r_work <= sh_result;
                  r_rem  <= r_rem >> w_k;
               end
            end
            ST_DONE: begin
               r_out_vld <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= ST_IDLE;
            end
            default: begin
               r_out_vld <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_seq.sv
// Bench for shift_add_seq: a per-cycle expectation queue built from the product and the
// coefficient's set-bit positions, compared every cycle, plus hand-computed directed cases.
module tb_shift_add_seq;
   localparam int IW = 8;
   localparam int CW = 8;
   localparam int OW = 21;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [IW-1:0] in_data = '0;
   logic [CW-1:0] coef = '0;
   logic [OW-1:0] sh_result;
   logic [OW-1:0] sh_data;
   logic [OW-1:0] out_data;
   logic          select_line_vld;
   logic [1:0]    i_shifter_count;
   logic          busy;
   logic          out_vld;

   int n_pass  = 0;
   int n_total = 0;

   shift_add_seq #(.IN_DATA_WIDTH(IW), .COEF_WIDTH(CW), .OUT_DATA_WIDTH(OW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .coef(coef),
      .sh_result(sh_result), .select_line_vld(select_line_vld),
      .i_shifter_count(i_shifter_count), .sh_data(sh_data), .busy(busy),
      .out_vld(out_vld), .out_data(out_data)
   );

   always #5 clk = ~clk;

   // External shifter: plain left shift, bits past the MSB are lost
   assign sh_result = sh_data << i_shifter_count;

   typedef struct packed {
      logic          sel;
      logic [1:0]    cnt;
      logic [OW-1:0] shd;
      logic          busy;
      logic          ovld;
      logic [OW-1:0] od;
   } exp_t;

   exp_t q[$];
   exp_t cur = '0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // Expected cycles of one op: per set bit, shifts of at most 3 to reach it, then an add;
   // then the terminating step and the DONE cycle carrying the product.
   function automatic void build(input logic [IW-1:0] d, input logic [CW-1:0] c,
                                 input logic [OW-1:0] prev_od);
      exp_t   e;
      int     pos = 0;
      longint prod = (longint'(d) * longint'(c)) % (longint'(1) << OW);
      for (int b = 0; b < CW; b++) begin
         if (c[b]) begin
            int gap = b - pos;
            while (gap > 0) begin
               int k = (gap > 3) ? 3 : gap;
               e = '0; e.busy = 1'b1; e.od = prev_od; e.sel = 1'b1;
               e.cnt = 2'(k);
               e.shd = OW'((longint'(d) << pos) % (longint'(1) << OW));
               q.push_back(e);
               pos += k;
               gap -= k;
            end
            e = '0; e.busy = 1'b1; e.od = prev_od;
            q.push_back(e);
         end
      end
      e = '0; e.busy = 1'b1; e.od = prev_od;
      q.push_back(e);
      e = '0; e.busy = 1'b1; e.ovld = 1'b1; e.od = OW'(prod);
      q.push_back(e);
   endfunction

   // Reference model: advances one expected cycle per clock, accepts start only after an idle cycle
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         cur <= '0;
      end else if (q.size() != 0) begin
         cur <= q.pop_front();
      end else if (!cur.busy && start) begin
         build(in_data, coef, cur.od);
         cur <= q.pop_front();
      end else begin
         cur <= '{sel: 1'b0, cnt: 2'd0, shd: '0, busy: 1'b0, ovld: 1'b0, od: cur.od};
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy", busy, cur.busy);
         chk("out_vld", out_vld, cur.ovld);
         chk("out_data", out_data, cur.od);
         chk("select_line_vld", select_line_vld, cur.sel);
         chk("i_shifter_count", i_shifter_count, cur.cnt);
         if (cur.sel) chk("sh_data", sh_data, cur.shd);
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_out_vld"}, out_vld, 0);
      chk({tag, "_sel"}, select_line_vld, 0);
      chk({tag, "_cnt"}, i_shifter_count, 0);
      chk({tag, "_sh_data"}, sh_data, 0);
      chk({tag, "_out_data"}, out_data, 0);
   endtask

   task automatic run_op(input string tag, input logic [IW-1:0] d, input logic [CW-1:0] c,
                         input int exp_prod, input int exp_lat, input int exp_shifts);
      int lat = 0;
      int shifts = 0;
      @(posedge clk); #1;
      start = 1'b1; in_data = d; coef = c;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= 40 && lat == 0; i++) begin
         @(negedge clk);
         if (select_line_vld) shifts++;
         if (out_vld) lat = i;
      end
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_product"}, out_data, exp_prod);
      chk({tag, "_shift_cycles"}, shifts, exp_shifts);
      @(negedge clk);
      chk({tag, "_single_pulse"}, out_vld, 0);
   endtask

   initial begin
      int p1 = 0, p2 = 0, pulses = 0;
      longint d1 = 0, d2 = 0;

      #2;
      check_all_zero("por");
      #20 rst_n = 1'b1;

      run_op("m25x5", 8'd25, 8'd5, 125, 5, 1);
      run_op("m3x128", 8'd3, 8'h80, 384, 6, 3);
      run_op("m255x255", 8'd255, 8'hFF, 65025, 17, 7);

      // Abort mid-RUN (on the k=2 shift step) with reset
      @(posedge clk); #1;
      start = 1'b1; in_data = 8'd25; coef = 8'd5;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_sel", select_line_vld, 1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("mid_reset");
      #4 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_vld) pulses++;
      end
      chk("post_reset_no_vld", pulses, 0);
      chk("post_reset_idle", busy, 0);

      run_op("m200x0", 8'd200, 8'd0, 0, 2, 0);

      // start held high across two ops; the changed operands during the first op are ignored
      @(posedge clk); #1;
      start = 1'b1; in_data = 8'd9; coef = 8'd7;
      @(posedge clk); #1;
      in_data = 8'd4; coef = 8'd2;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (out_vld && p1 == 0) begin
            p1 = i; d1 = out_data;
         end else if (out_vld) begin
            p2 = i; d2 = out_data; start = 1'b0;
         end
         if (i == 10) chk("b2b_hold_63", out_data, 63);
      end
      chk("b2b_first_cycle", p1, 7);
      chk("b2b_first_data", d1, 63);
      chk("b2b_second_cycle", p2, 12);
      chk("b2b_second_data", d2, 8);
      chk("b2b_idle_busy", busy, 0);
      chk("b2b_held_8", out_data, 8);

      // Randomized traffic, checked by the every-cycle model comparison
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         start = ($urandom_range(0, 2) == 0);
         in_data = IW'($urandom);
         case ($urandom_range(0, 3))
            0:       coef = 8'd0;
            1:       coef = 8'd1 << $urandom_range(0, 7);
            default: coef = CW'($urandom);
         endcase
      end
      start = 1'b0;
      repeat (25) @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
